// File: rtl/drac_pkg.sv
// drac_pkg: shared core/cache types, including the load kind used by the response path
package drac_pkg;

    typedef enum logic [2:0] {
        LD_B  = 3'd0,
        LD_BU = 3'd1,
        LD_H  = 3'd2,
        LD_HU = 3'd3,
        LD_W  = 3'd4,
        LD_WU = 3'd5,
        LD_D  = 3'd6
    } ld_kind_t;

    // Offset bits that must be zero for a naturally aligned access of this kind
    function automatic logic [2:0] ld_align_mask(input ld_kind_t k);
        return (k == LD_B || k == LD_BU) ? 3'b000 :
               (k == LD_H || k == LD_HU) ? 3'b001 :
               (k == LD_W || k == LD_WU) ? 3'b011 : 3'b111;
    endfunction

endpackage

// File: rtl/lagarto_dcache_resp_if.sv
// lagarto_dcache_resp_if: load issue, cache response and core result signals of the response adapter
interface lagarto_dcache_resp_if
    import drac_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int RD_W  = 6
);
    logic                     ld_issue_valid_i;
    ld_kind_t                 ld_issue_kind_i;
    logic [2:0]               ld_issue_offset_i;
    logic [RD_W-1:0]          ld_issue_rd_i;
    logic                     ld_issue_ready_o;
    logic                     kill_i;
    logic                     ld_resp_valid_i;
    logic [63:0]              ld_resp_data_i;
    logic                     resp_valid_o;
    logic [63:0]              resp_data_o;
    logic [RD_W-1:0]          resp_rd_o;
    logic [$clog2(DEPTH):0]   outstanding_o;
    logic                     err_o;

    modport master (
        output ld_issue_valid_i, ld_issue_kind_i, ld_issue_offset_i, ld_issue_rd_i,
        output kill_i, ld_resp_valid_i, ld_resp_data_i,
        input  ld_issue_ready_o, resp_valid_o, resp_data_o, resp_rd_o, outstanding_o, err_o
    );

    modport slave (
        input  ld_issue_valid_i, ld_issue_kind_i, ld_issue_offset_i, ld_issue_rd_i,
        input  kill_i, ld_resp_valid_i, ld_resp_data_i,
        output ld_issue_ready_o, resp_valid_o, resp_data_o, resp_rd_o, outstanding_o, err_o
    );
endinterface

// File: rtl/lagarto_load_align.sv
// lagarto_load_align: extracts the addressed field of a doubleword and sign/zero-extends it
module lagarto_load_align
    import drac_pkg::*;
(
    input  ld_kind_t    i_kind,
    input  logic [2:0]  i_offset,
    input  logic [63:0] i_data,
    output logic [63:0] o_data
);
    logic [7:0]  w_b;
    logic [15:0] w_h;
    logic [31:0] w_w;

    assign w_b = i_data[{i_offset, 3'b000} +: 8];
    assign w_h = i_data[{i_offset[2:1], 4'b0000} +: 16];
    assign w_w = i_data[{i_offset[2], 5'b00000} +: 32];

    // Select field by access size, then extend by signedness
    always_comb begin
        o_data = (i_kind == LD_B)  ? {{56{w_b[7]}}, w_b}  :
                 (i_kind == LD_BU) ? {56'd0, w_b}         :
                 (i_kind == LD_H)  ? {{48{w_h[15]}}, w_h} :
                 (i_kind == LD_HU) ? {48'd0, w_h}         :
                 (i_kind == LD_W)  ? {{32{w_w[31]}}, w_w} :
                 (i_kind == LD_WU) ? {32'd0, w_w}         : i_data;
    end
endmodule

// File: rtl/lagarto_dcache_resp_adapter.sv
// lagarto_dcache_resp_adapter: matches in-order cache load responses to issue metadata, drops killed loads
module lagarto_dcache_resp_adapter
    import drac_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int RD_W  = 6
) (
    input logic clk_i,
    input logic rst_i,
    lagarto_dcache_resp_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ld_kind_t         r_kind [DEPTH];
    logic [2:0]       r_off  [DEPTH];
    logic [RD_W-1:0]  r_rd   [DEPTH];
    logic [DEPTH-1:0] r_killed;
    logic [PW-1:0]    r_wp, r_rp;
    logic [CW-1:0]    r_cnt;
    logic             r_resp_valid;
    logic [63:0]      r_resp_data;
    logic [RD_W-1:0]  r_resp_rd;
    logic             r_err;

    logic        w_full, w_empty, w_push, w_pop, w_live, w_misaligned;
    logic [63:0] w_aligned;

    assign w_full       = r_cnt == CW'(DEPTH);
    assign w_empty      = r_cnt == '0;
    assign w_push       = bus.ld_issue_valid_i && !w_full;
    assign w_pop        = bus.ld_resp_valid_i && !w_empty;
    // A head popped in the kill cycle is dropped just like an already-killed one
    assign w_live       = w_pop && !(r_killed[r_rp] || bus.kill_i);
    assign w_misaligned = (bus.ld_issue_offset_i & ld_align_mask(bus.ld_issue_kind_i)) != 3'b000;

    lagarto_load_align u_align (
        .i_kind   (r_kind[r_rp]),
        .i_offset (r_off[r_rp]),
        .i_data   (bus.ld_resp_data_i),
        .o_data   (w_aligned)
    );

    // Metadata FIFO, kill marking, registered result and sticky protocol error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_kind[i] <= LD_B;
                r_off[i]  <= '0;
                r_rd[i]   <= '0;
            end
            r_killed     <= '0;
            r_wp         <= '0;
            r_rp         <= '0;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_rd    <= '0;
            r_err        <= 1'b0;
        end else begin
            if (bus.kill_i) r_killed <= '1;
            if (w_push) begin
                r_kind[r_wp]   <= bus.ld_issue_kind_i;
                r_off[r_wp]    <= bus.ld_issue_offset_i;
                r_rd[r_wp]     <= bus.ld_issue_rd_i;
                r_killed[r_wp] <= bus.kill_i;
                r_wp           <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt        <= r_cnt + CW'(w_push) - CW'(w_pop);
            r_resp_valid <= w_live;
            if (w_live) begin
                r_resp_data <= w_aligned;
                r_resp_rd   <= r_rd[r_rp];
            end
            r_err <= r_err || (bus.ld_issue_valid_i && w_full) || (bus.ld_resp_valid_i && w_empty);
        end
    end

    assign bus.ld_issue_ready_o = !w_full;
    assign bus.resp_valid_o     = r_resp_valid;
    assign bus.resp_data_o      = r_resp_data;
    assign bus.resp_rd_o        = r_resp_rd;
    assign bus.outstanding_o    = r_cnt;
    assign bus.err_o            = r_err;

    a_issue_aligned: assert property (@(posedge clk_i) disable iff (rst_i) bus.ld_issue_valid_i |-> !w_misaligned);
endmodule

// File: tb/tb_lagarto_dcache_resp_adapter.sv
// tb_lagarto_dcache_resp_adapter: randomized and directed checks against a queue-based load model
module tb_lagarto_dcache_resp_adapter;
    import drac_pkg::*;

    localparam int DEPTH = 2;
    localparam int RD_W  = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        ld_kind_t   kind;
        logic [2:0] off;
        logic [5:0] rd;
        bit         killed;
    } ent_t;

    ent_t        q[$];
    bit          exp_valid;
    logic [63:0] exp_data;
    logic [5:0]  exp_rd;
    bit          exp_err;

    lagarto_dcache_resp_if #(.DEPTH(DEPTH), .RD_W(RD_W)) bus ();

    lagarto_dcache_resp_adapter #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int size_of(input ld_kind_t k);
        return (k == LD_B || k == LD_BU) ? 1 : (k == LD_H || k == LD_HU) ? 2 : (k == LD_W || k == LD_WU) ? 4 : 8;
    endfunction

    function automatic logic [63:0] ref_load(input ld_kind_t k, input logic [2:0] off, input logic [63:0] d);
        int          sz;
        int          bits;
        int          aoff;
        logic [63:0] mask;
        logic [63:0] v;
        sz   = size_of(k);
        bits = sz * 8;
        aoff = (int'(off) / sz) * sz;
        mask = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
        v    = (d >> (aoff * 8)) & mask;
        if ((k == LD_B || k == LD_H || k == LD_W) && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [2:0] rand_off(input ld_kind_t k);
        logic [2:0] o;
        o = 3'($urandom_range(0, 7));
        return o & ~3'(size_of(k) - 1);
    endfunction

    task automatic model_reset();
        q.delete();
        exp_valid = 0;
        exp_data  = '0;
        exp_rd    = '0;
        exp_err   = 0;
    endtask

    task automatic step(input bit iv, input ld_kind_t k, input logic [2:0] o, input logic [5:0] rd,
                        input bit kl, input bit rv, input logic [63:0] d);
        bit   full;
        bit   empty;
        ent_t e;
        bus.ld_issue_valid_i  = iv;
        bus.ld_issue_kind_i   = k;
        bus.ld_issue_offset_i = o;
        bus.ld_issue_rd_i     = rd;
        bus.kill_i            = kl;
        bus.ld_resp_valid_i   = rv;
        bus.ld_resp_data_i    = d;
        @(posedge clk);
        full  = q.size() == DEPTH;
        empty = q.size() == 0;
        if ((iv && full) || (rv && empty)) exp_err = 1;
        if (kl) foreach (q[i]) q[i].killed = 1;
        exp_valid = 0;
        if (rv && !empty) begin
            e = q.pop_front();
            if (!e.killed && !kl) begin
                exp_valid = 1;
                exp_data  = ref_load(e.kind, e.off, d);
                exp_rd    = e.rd;
            end
        end
        if (iv && !full) q.push_back('{kind: k, off: o, rd: rd, killed: kl});
        #1;
        bus.ld_issue_valid_i = 0;
        bus.kill_i           = 0;
        bus.ld_resp_valid_i  = 0;
        bus.ld_resp_data_i   = '0;
    endtask

    task automatic test_reset();
        bus.ld_issue_valid_i  = 0;
        bus.ld_issue_kind_i   = LD_B;
        bus.ld_issue_offset_i = '0;
        bus.ld_issue_rd_i     = '0;
        bus.kill_i            = 0;
        bus.ld_resp_valid_i   = 0;
        bus.ld_resp_data_i    = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        #1;
        checks++; if (bus.resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.resp_valid_o); end
        checks++; if (bus.resp_data_o !== 64'd0) begin errors++; $display("FAIL reset_data got %h want 0", bus.resp_data_o); end
        checks++; if (bus.resp_rd_o !== 6'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", bus.resp_rd_o); end
        checks++; if (bus.outstanding_o !== 2'd0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", bus.outstanding_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", bus.err_o); end
        checks++; if (bus.ld_issue_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", bus.ld_issue_ready_o); end
    endtask

    task automatic test_extract();
        ld_kind_t    kinds [6] = '{LD_B, LD_BU, LD_W, LD_WU, LD_HU, LD_D};
        logic [2:0]  offs  [6] = '{3'd5, 3'd5, 3'd4, 3'd4, 3'd2, 3'd0};
        logic [63:0] datas [6] = '{64'h0000_80FF_0000_0000, 64'h0000_80FF_0000_0000, 64'h8000_0001_1234_5678,
                                   64'h8000_0001_1234_5678, 64'h8000_0001_1234_5678, 64'h8000_0001_1234_5678};
        logic [63:0] wants [6] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80, 64'hFFFF_FFFF_8000_0001,
                                   64'h8000_0001, 64'h1234, 64'h8000_0001_1234_5678};
        for (int i = 0; i < 6; i++) begin
            step(1, kinds[i], offs[i], 6'(i + 1), 0, 0, '0);
            checks++; if (bus.resp_valid_o !== 1'b0) begin errors++; $display("FAIL extract%0d_early_valid got %0b want 0", i, bus.resp_valid_o); end
            step(0, LD_B, 0, 0, 0, 1, datas[i]);
            checks++; if (bus.resp_valid_o !== 1'b1) begin errors++; $display("FAIL extract%0d_valid got %0b want 1", i, bus.resp_valid_o); end
            checks++; if (bus.resp_data_o !== wants[i]) begin errors++; $display("FAIL extract%0d_data got %h want %h", i, bus.resp_data_o, wants[i]); end
            checks++; if (bus.resp_rd_o !== 6'(i + 1)) begin errors++; $display("FAIL extract%0d_rd got %0d want %0d", i, bus.resp_rd_o, i + 1); end
            step(0, LD_B, 0, 0, 0, 0, '0);
            checks++; if (bus.resp_valid_o !== 1'b0) begin errors++; $display("FAIL extract%0d_pulse got %0b want 0", i, bus.resp_valid_o); end
            checks++; if (bus.resp_data_o !== wants[i]) begin errors++; $display("FAIL extract%0d_hold got %h want %h", i, bus.resp_data_o, wants[i]); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            bit       iv;
            bit       rv;
            bit       kl;
            ld_kind_t k;
            iv = (q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
            rv = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            kl = $urandom_range(0, 15) == 0;
            k  = ld_kind_t'($urandom_range(0, 6));
            step(iv, k, rand_off(k), 6'($urandom), kl, rv, {$urandom, $urandom});
            checks++; if (bus.resp_valid_o !== exp_valid) begin errors++; $display("FAIL rand%0d_valid got %0b want %0b", n, bus.resp_valid_o, exp_valid); end
            checks++; if (bus.resp_data_o !== exp_data) begin errors++; $display("FAIL rand%0d_data got %h want %h", n, bus.resp_data_o, exp_data); end
            checks++; if (bus.resp_rd_o !== exp_rd) begin errors++; $display("FAIL rand%0d_rd got %0d want %0d", n, bus.resp_rd_o, exp_rd); end
            checks++; if (bus.outstanding_o !== 2'(q.size())) begin errors++; $display("FAIL rand%0d_outstanding got %0d want %0d", n, bus.outstanding_o, q.size()); end
            checks++; if (bus.ld_issue_ready_o !== (q.size() != DEPTH)) begin errors++; $display("FAIL rand%0d_ready got %0b want %0b", n, bus.ld_issue_ready_o, q.size() != DEPTH); end
            checks++; if (bus.err_o !== exp_err) begin errors++; $display("FAIL rand%0d_err got %0b want %0b", n, bus.err_o, exp_err); end
        end
        while (q.size() > 0) step(0, LD_B, 0, 0, 0, 1, {$urandom, $urandom});
        step(0, LD_B, 0, 0, 0, 0, '0);
    endtask

    task automatic test_back_to_back();
        step(1, LD_D, 0, 6'd3, 0, 0, '0);
        checks++; if (bus.outstanding_o !== 2'd1) begin errors++; $display("FAIL b2b_out1 got %0d want 1", bus.outstanding_o); end
        step(1, LD_HU, 3'd6, 6'd7, 0, 0, '0);
        checks++; if (bus.outstanding_o !== 2'd2) begin errors++; $display("FAIL b2b_out2 got %0d want 2", bus.outstanding_o); end
        checks++; if (bus.ld_issue_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got %0b want 0", bus.ld_issue_ready_o); end
        step(0, LD_B, 0, 0, 0, 1, 64'h1111_2222_3333_4444);
        checks++; if (bus.resp_rd_o !== 6'd3 || bus.resp_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_rd3 got %0d/%0b want 3/1", bus.resp_rd_o, bus.resp_valid_o); end
        checks++; if (bus.outstanding_o !== 2'd1) begin errors++; $display("FAIL b2b_out3 got %0d want 1", bus.outstanding_o); end
        step(0, LD_B, 0, 0, 0, 1, 64'hABCD_2222_3333_4444);
        checks++; if (bus.resp_rd_o !== 6'd7 || bus.resp_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_rd7 got %0d/%0b want 7/1", bus.resp_rd_o, bus.resp_valid_o); end
        checks++; if (bus.resp_data_o !== 64'hABCD) begin errors++; $display("FAIL b2b_data7 got %h want abcd", bus.resp_data_o); end
        checks++; if (bus.outstanding_o !== 2'd0) begin errors++; $display("FAIL b2b_out4 got %0d want 0", bus.outstanding_o); end
    endtask

    task automatic test_kill();
        step(1, LD_W, 0, 6'd1, 0, 0, '0);
        step(1, LD_W, 4, 6'd2, 0, 0, '0);
        step(0, LD_B, 0, 0, 1, 0, '0);
        step(0, LD_B, 0, 0, 0, 1, {$urandom, $urandom});
        checks++; if (bus.resp_valid_o !== 1'b0) begin errors++; $display("FAIL kill_resp1 got %0b want 0", bus.resp_valid_o); end
        step(0, LD_B, 0, 0, 0, 1, {$urandom, $urandom});
        checks++; if (bus.resp_valid_o !== 1'b0) begin errors++; $display("FAIL kill_resp2 got %0b want 0", bus.resp_valid_o); end
        checks++; if (bus.outstanding_o !== 2'd0) begin errors++; $display("FAIL kill_out got %0d want 0", bus.outstanding_o); end
        step(1, LD_BU, 3'd1, 6'd9, 0, 0, '0);
        step(0, LD_B, 0, 0, 0, 1, 64'h0000_0000_0000_9A00);
        checks++; if (bus.resp_valid_o !== 1'b1 || bus.resp_rd_o !== 6'd9) begin errors++; $display("FAIL kill_new got %0b/%0d want 1/9", bus.resp_valid_o, bus.resp_rd_o); end
        checks++; if (bus.resp_data_o !== 64'h9A) begin errors++; $display("FAIL kill_new_data got %h want 9a", bus.resp_data_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL kill_err got %0b want 0", bus.err_o); end
    endtask

    task automatic test_errors();
        step(0, LD_B, 0, 0, 0, 1, 64'h55);
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_empty got %0b want 1", bus.err_o); end
        checks++; if (bus.resp_valid_o !== 1'b0 || bus.outstanding_o !== 2'd0) begin errors++; $display("FAIL err_empty_state got %0b/%0d want 0/0", bus.resp_valid_o, bus.outstanding_o); end
        step(1, LD_H, 3'd2, 6'd11, 0, 0, '0);
        step(1, LD_B, 3'd7, 6'd12, 0, 0, '0);
        step(1, LD_D, 3'd0, 6'd13, 0, 0, '0);
        checks++; if (bus.outstanding_o !== 2'd2 || bus.err_o !== 1'b1) begin errors++; $display("FAIL err_full got %0d/%0b want 2/1", bus.outstanding_o, bus.err_o); end
        step(0, LD_B, 0, 0, 0, 1, 64'h0000_0000_8001_0000);
        checks++; if (bus.resp_rd_o !== 6'd11 || bus.resp_data_o !== 64'hFFFF_FFFF_FFFF_8001) begin errors++; $display("FAIL err_head got %0d/%h want 11/ffffffffffff8001", bus.resp_rd_o, bus.resp_data_o); end
        step(0, LD_B, 0, 0, 0, 1, 64'h7F00_0000_0000_0000);
        checks++; if (bus.resp_rd_o !== 6'd12 || bus.resp_data_o !== 64'h7F) begin errors++; $display("FAIL err_second got %0d/%h want 12/7f", bus.resp_rd_o, bus.resp_data_o); end
        checks++; if (bus.outstanding_o !== 2'd0 || bus.err_o !== exp_err) begin errors++; $display("FAIL err_sticky got %0d/%0b want 0/%0b", bus.outstanding_o, bus.err_o, exp_err); end
    endtask

    task automatic test_reset_mid();
        step(1, LD_D, 0, 6'd20, 0, 0, '0);
        step(1, LD_D, 0, 6'd21, 0, 0, '0);
        step(0, LD_B, 0, 0, 0, 1, 64'h1);
        checks++; if (bus.resp_valid_o !== 1'b1) begin errors++; $display("FAIL rmid_pre got %0b want 1", bus.resp_valid_o); end
        #1;
        rst = 1;
        model_reset();
        #1;
        checks++; if (bus.resp_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid got %0b want 0", bus.resp_valid_o); end
        checks++; if (bus.outstanding_o !== 2'd0) begin errors++; $display("FAIL rmid_out got %0d want 0", bus.outstanding_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL rmid_err got %0b want 0", bus.err_o); end
        @(posedge clk);
        #1;
        rst = 0;
        step(0, LD_B, 0, 0, 0, 1, 64'h2);
        checks++; if (bus.err_o !== 1'b1 || bus.resp_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_late got %0b/%0b want 1/0", bus.err_o, bus.resp_valid_o); end
    endtask

    initial begin
        test_reset();
        test_extract();
        test_random();
        test_back_to_back();
        test_kill();
        test_errors();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lagarto_dcache_resp_adapter.md
# lagarto_dcache_resp_adapter

Response-side adapter between the L1 data cache subsystem and the Lagarto core: the return path for load requests issued by the core-side dcache request interface. It records per-load metadata (kind, byte offset, destination register) in issue order. It matches each in-order cache load response to its metadata, extracts and sign/zero-extends the loaded value, and returns a registered response to the core. Outstanding loads can be killed on a pipeline flush; their late responses are consumed and dropped.

## Interface
- DEPTH, 2, maximum outstanding loads (power of two, ≥2)
- RD_W, 6, destination register tag width
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- ld_issue_valid_i  in  1  load accepted by cache this cycle (same cycle as ld_mem_req_valid with tag_valid)
- ld_issue_kind_i  in  3  ld_kind_t: B, BU, H, HU, W, WU, D
- ld_issue_offset_i  in  3  paddr[2:0] of the load
- ld_issue_rd_i  in  RD_W  destination register
- ld_issue_ready_o  out  1  buffer can accept an issue this cycle
- kill_i  in  1  flush: kill every outstanding load
- ld_resp_valid_i  in  1  cache load response valid (in order, one per issued load)
- ld_resp_data_i  in  64  raw aligned 64-bit doubleword from cache
- resp_valid_o  out  1  completed, non-killed load result valid (one-cycle pulse)
- resp_data_o  out  64  extended load result
- resp_rd_o  out  RD_W  destination register of result
- outstanding_o  out  $clog2(DEPTH)+1  entries currently occupied
- err_o  out  1  sticky protocol error

## Operation
- Circular FIFO of DEPTH entries {kind, offset, rd, killed}; write pointer, read pointer, count.
- Push when ld_issue_valid_i; pop when ld_resp_valid_i. Both in one cycle: count unchanged.
- ld_issue_ready_o = (count != DEPTH); combinational from count only (not from same-cycle pop).
- Issue while full: dropped, no state change, err_o set. Response while empty: ignored, err_o set. err_o clears only on reset.
- kill_i: sets killed on all valid entries, and on an entry pushed the same cycle. Pop of a head entry in the kill cycle is also treated as killed.
- Pop of killed entry: response consumed, resp_valid_o stays 0.
- Pop of live entry: extraction from ld_resp_data_i with head offset/kind:
  - B/BU: data[offset*8 +: 8]
  - H/HU: data[offset[2:1]*16 +: 16]
  - W/WU: data[offset[2]*32 +: 32]
  - D: data
  - B, H, W sign-extend to 64; BU, HU, WU zero-extend.
- Offset low bits below access size are ignored (upstream guarantees alignment). An assertion flags a misaligned issue.
- Pointers wrap modulo DEPTH.

## Timing
- Reset: all outputs 0, count 0, pointers 0, all killed bits 0; ld_issue_ready_o 1 once rst_i deasserts.
- Response latency: resp_valid_o/resp_data_o/resp_rd_o registered, one cycle after ld_resp_valid_i.
- resp_data_o and resp_rd_o hold their last value when resp_valid_o is 0.
- outstanding_o is the registered count, updated the cycle after push/pop.
- Reset mid-operation: all entries discarded immediately. A pending resp_valid_o is cleared asynchronously.
- Minimum issue-to-response: cache may respond the cycle after issue. A same-cycle issue and response to an empty buffer is illegal; it sets err_o and the issue is still pushed.

## Structure
- ld_kind_t (3-bit enum) goes in drac_pkg, next to the existing instr_type enum, so the request side can map instr_type to ld_kind_t.
- Sub-module lagarto_load_align: purely combinational extract + extend (kind, offset, 64-bit data → 64-bit result). It is reused by the non-cacheable path.
- FIFO storage stays inline; no generic FIFO instance.

## Test plan
- Single LB at offset 5, data 0x0000_80FF_0000_0000 → resp_data_o 0xFFFF_FFFF_FFFF_FF80 one cycle after response; LBU same data → 0x80.
- LW offset 4, data 0x8000_0001_1234_5678 → 0xFFFF_FFFF_8000_0001; LWU → 0x8000_0001; LHU offset 2 → 0x1234; LD → full data.
- Issue rd 3 then rd 7 back-to-back, respond twice → resp_rd_o 3 then 7; outstanding_o goes 1,2,1,0; ld_issue_ready_o 0 while count 2 (DEPTH=2).
- Two outstanding loads, kill_i pulse, then two responses → no resp_valid_o. A new load (rd 9) issued after the kill returns normally with rd 9.
- Response with buffer empty, and issue with buffer full → err_o rises and stays 1; FIFO contents and count unchanged.
- Assert rst_i with one load outstanding → outstanding_o 0, resp_valid_o 0. A response after reset release sets err_o.
